// File: rtl/imm_enc_pkg.sv
// Shared immediate-format constants for the encoder and the core's immediate-extend logic.
// Provides the immsrc codes, per-format field masks and the field-placement helper.
package imm_enc_pkg;

    localparam logic [1:0] IMMSRC_I = 2'b00;
    localparam logic [1:0] IMMSRC_S = 2'b01;
    localparam logic [1:0] IMMSRC_B = 2'b10;
    localparam logic [1:0] IMMSRC_J = 2'b11;

    localparam logic [31:0] IMM_MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] IMM_MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] IMM_MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] IMM_MASK_J = 32'hFFFF_F000;

    function automatic logic [31:0] imm_mask(input logic [1:0] immsrc);
        case (immsrc)
            IMMSRC_I: imm_mask = IMM_MASK_I;
            IMMSRC_S: imm_mask = IMM_MASK_S;
            IMMSRC_B: imm_mask = IMM_MASK_B;
            IMMSRC_J: imm_mask = IMM_MASK_J;
            default:  imm_mask = IMM_MASK_I;
        endcase
    endfunction

    // Scatter the immediate into its instruction bit positions; bits outside the field are zero.
    function automatic logic [31:0] imm_place(input logic [1:0] immsrc, input logic [31:0] imm);
        case (immsrc)
            IMMSRC_I: imm_place = {imm[11:0], 20'h0_0000};
            IMMSRC_S: imm_place = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
            IMMSRC_B: imm_place = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
            IMMSRC_J: imm_place = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
            default:  imm_place = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational range/alignment check for an immediate in a given RISC-V format.
// Only instantiated when IMM_ENC_RANGE_CHECK_EN is defined.
module imm_range_check
    import imm_enc_pkg::*;
(
    input  logic [1:0]  immsrc,
    input  logic [31:0] imm,
    output logic        err
);

    logic sext12_ok_s;
    logic sext13_ok_s;
    logic sext21_ok_s;
    logic unused_imm_s;

    // A field fits when every bit above its sign bit copies the sign.
    assign sext12_ok_s  = (&imm[31:11]) | ~(|imm[31:11]);
    assign sext13_ok_s  = (&imm[31:12]) | ~(|imm[31:12]);
    assign sext21_ok_s  = (&imm[31:20]) | ~(|imm[31:20]);
    assign unused_imm_s = ^imm[10:1];

    // Select the rule for the requested format.
    always_comb begin
        err = 1'b0;
        case (immsrc)
            IMMSRC_I: err = ~sext12_ok_s;
            IMMSRC_S: err = ~sext12_ok_s;
            IMMSRC_B: err = ~sext13_ok_s | imm[0];
            IMMSRC_J: err = ~sext21_ok_s | imm[0];
            default:  err = 1'b0;
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// Two-stage valid/ready immediate encoder packing a signed immediate into I/S/B/J positions.
// Define IMM_ENC_RANGE_CHECK_EN to compile the range/alignment check, out_err and err_count.
module imm_encode
    import imm_enc_pkg::*;
#(
    parameter int ENC_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_immsrc,
    input  logic [31:0]          in_imm,
    input  logic [31:0]          in_base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ENC_CNT_W-1:0] enc_count,
    output logic [7:0]           err_count
);

    logic                 s1_v_q, s1_v_d;
    logic [31:0]          s1_base_q, s1_base_d;
    logic [31:0]          s1_mask_q, s1_mask_d;
    logic [31:0]          s1_place_q, s1_place_d;
    logic                 s2_v_q, s2_v_d;
    logic [31:0]          out_instr_q, out_instr_d;
    logic [ENC_CNT_W-1:0] enc_count_q, enc_count_d;
    logic                 s1_rdy_s, s2_rdy_s, out_hs_s;
`ifdef IMM_ENC_RANGE_CHECK_EN
    logic                 range_err_s;
    logic                 s1_err_q, s1_err_d;
    logic                 out_err_q, out_err_d;
    logic [7:0]           err_count_q, err_count_d;

    imm_range_check u_range_check (
        .immsrc (in_immsrc),
        .imm    (in_imm),
        .err    (range_err_s)
    );
`endif

    assign s2_rdy_s = ~s2_v_q | out_ready;
    assign s1_rdy_s = ~s1_v_q | s2_rdy_s;
    assign out_hs_s = s2_v_q & out_ready;

    // Next-state logic for both pipeline stages and the handshake counters.
    always_comb begin
        s1_v_d      = s1_v_q;
        s1_base_d   = s1_base_q;
        s1_mask_d   = s1_mask_q;
        s1_place_d  = s1_place_q;
        s2_v_d      = s2_v_q;
        out_instr_d = out_instr_q;
        enc_count_d = enc_count_q;
        if (s1_rdy_s) begin
            s1_v_d = in_valid;
        end else begin
            s1_v_d = s1_v_q;
        end
        if (in_valid && s1_rdy_s) begin
            s1_base_d  = in_base;
            s1_mask_d  = imm_mask(in_immsrc);
            s1_place_d = imm_place(in_immsrc, in_imm);
        end else begin
            s1_base_d  = s1_base_q;
        end
        if (s2_rdy_s) begin
            s2_v_d = s1_v_q;
        end else begin
            s2_v_d = s2_v_q;
        end
        if (s1_v_q && s2_rdy_s) begin
            out_instr_d = (s1_base_q & ~s1_mask_q) | s1_place_q;
        end else begin
            out_instr_d = out_instr_q;
        end
        if (out_hs_s) begin
            enc_count_d = enc_count_q + ENC_CNT_W'(1);
        end else begin
            enc_count_d = enc_count_q;
        end
`ifdef IMM_ENC_RANGE_CHECK_EN
        s1_err_d    = s1_err_q;
        out_err_d   = out_err_q;
        err_count_d = err_count_q;
        if (in_valid && s1_rdy_s) begin
            s1_err_d = range_err_s;
        end else begin
            s1_err_d = s1_err_q;
        end
        if (s1_v_q && s2_rdy_s) begin
            out_err_d = s1_err_q;
        end else begin
            out_err_d = out_err_q;
        end
        if (out_hs_s && out_err_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
`endif
    end

    // Pipeline and counter registers; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_base_q   <= 32'h0000_0000;
            s1_mask_q   <= 32'h0000_0000;
            s1_place_q  <= 32'h0000_0000;
            s2_v_q      <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            enc_count_q <= '0;
`ifdef IMM_ENC_RANGE_CHECK_EN
            s1_err_q    <= 1'b0;
            out_err_q   <= 1'b0;
            err_count_q <= 8'h00;
`endif
        end else begin
            s1_v_q      <= s1_v_d;
            s1_base_q   <= s1_base_d;
            s1_mask_q   <= s1_mask_d;
            s1_place_q  <= s1_place_d;
            s2_v_q      <= s2_v_d;
            out_instr_q <= out_instr_d;
            enc_count_q <= enc_count_d;
`ifdef IMM_ENC_RANGE_CHECK_EN
            s1_err_q    <= s1_err_d;
            out_err_q   <= out_err_d;
            err_count_q <= err_count_d;
`endif
        end
    end

    assign in_ready  = s1_rdy_s;
    assign out_valid = s2_v_q;
    assign out_instr = out_instr_q;
    assign enc_count = enc_count_q;
`ifdef IMM_ENC_RANGE_CHECK_EN
    assign out_err   = out_err_q;
    assign err_count = err_count_q;
`else
    assign out_err   = 1'b0;
    assign err_count = 8'h00;
`endif

endmodule
